// File: rtl/flappy_rng_pkg.sv
// Shared constants and types for the game RNG: LFSR geometry, tap positions,
// the lockup word and the per-cycle arbitration action.
package flappy_rng_pkg;

  localparam int LFSR_W = 16;
  localparam int TAP_A = 3;
  localparam int TAP_B = 12;
  localparam int TAP_C = 14;
  localparam int TAP_D = 15;

  localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 16'hFFFF;
  localparam logic [LFSR_W-1:0] LFSR_RESET  = 16'h0000;

  typedef enum logic [1:0] {
    ACT_IDLE  = 2'd0,
    ACT_SEED  = 2'd1,
    ACT_HOLD  = 2'd2,
    ACT_GRANT = 2'd3
  } rng_action_e;

  // XNOR feedback keeps all-zero legal; all-ones is the unreachable lockup word.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ~(s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D])};
  endfunction

endpackage

// File: rtl/lfsr16_step.sv
// 16-bit XNOR LFSR state register with step enable and seed load.
// A seed equal to the lockup word is replaced by the reset word.
module lfsr16_step
  import flappy_rng_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              Load,
  input  logic [LFSR_W-1:0] LoadValue,
  output logic [LFSR_W-1:0] State
);

  logic [LFSR_W-1:0] state_r;

  // Load outranks stepping; a hold keeps the current word.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= LFSR_RESET;
    end else if (Load) begin
      state_r <= (LoadValue == LFSR_LOCKUP) ? LFSR_RESET : LoadValue;
    end else if (Enable) begin
      state_r <= lfsr_next(state_r);
    end else begin
      state_r <= state_r;
    end
  end

  assign State = state_r;

endmodule

// File: rtl/rng_share_arbiter.sv
// Round-robin req/ack arbiter handing out one fresh LFSR word per grant
// to NUM_REQ game requesters; the LFSR steps exactly once per grant.
module rng_share_arbiter
  import flappy_rng_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter bit FREE_RUN = 1'b1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Freeze,
  input  logic               SeedLoad,
  input  logic [LFSR_W-1:0]  SeedValue,
  input  logic [NUM_REQ-1:0] Req,
  output logic [NUM_REQ-1:0] Ack,
  output logic [LFSR_W-1:0]  RandOut,
  output logic [15:0]        DrawCount
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] ack_r;
  logic [LFSR_W-1:0]  rand_r;
  logic [15:0]        count_r;
  logic [PTR_W-1:0]   ptr_r;

  logic [LFSR_W-1:0]  lfsr_s;
  logic [NUM_REQ-1:0] eligible_s;
  logic [NUM_REQ-1:0] mask_s;
  logic [NUM_REQ-1:0] pick_s;
  logic [PTR_W-1:0]   winner_s;
  logic [PTR_W-1:0]   ptr_next_s;
  logic [NUM_REQ-1:0] onehot_s;
  logic               lfsr_en_s;
  rng_action_e        action_s;

  // The requester acked this cycle is masked so a held Req cannot win twice in a row.
  assign eligible_s = Req & ~ack_r;

  // Rotate mask: requesters at or above the pointer are tried first.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask_s[i] = (i >= int'(ptr_r));
    end
  end

  // Lowest set bit of the masked set, falling back to the full set on wrap.
  always_comb begin
    pick_s   = ((eligible_s & mask_s) != '0) ? (eligible_s & mask_s) : eligible_s;
    winner_s = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      winner_s = pick_s[i] ? PTR_W'(i) : winner_s;
    end
  end

  assign onehot_s   = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
  assign ptr_next_s = (winner_s == PTR_W'(NUM_REQ - 1)) ? '0 : winner_s + PTR_W'(1);

  // Seed beats freeze beats grant beats free-run idle.
  always_comb begin
    action_s  = ACT_IDLE;
    lfsr_en_s = 1'b0;
    if (SeedLoad) begin
      action_s = ACT_SEED;
    end else if (Freeze) begin
      action_s = ACT_HOLD;
    end else if (eligible_s != '0) begin
      action_s  = ACT_GRANT;
      lfsr_en_s = 1'b1;
    end else begin
      action_s  = ACT_IDLE;
      lfsr_en_s = (FREE_RUN == 1'b1);
    end
  end

  lfsr16_step u_lfsr (
    .Clock     (Clock),
    .Reset     (Reset),
    .Enable    (lfsr_en_s),
    .Load      (SeedLoad),
    .LoadValue (SeedValue),
    .State     (lfsr_s)
  );

  // Grant edge publishes the pre-step word and rotates priority past the winner.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ack_r   <= '0;
      rand_r  <= LFSR_RESET;
      count_r <= 16'd0;
      ptr_r   <= '0;
    end else begin
      case (action_s)
        ACT_GRANT: begin
          ack_r   <= onehot_s;
          rand_r  <= lfsr_s;
          count_r <= count_r + 16'd1;
          ptr_r   <= ptr_next_s;
        end
        default: begin
          ack_r <= '0;
        end
      endcase
    end
  end

  assign Ack       = ack_r;
  assign RandOut   = rand_r;
  assign DrawCount = count_r;

endmodule
